// File: rtl/debug_control_pkg.sv
// Shared constants for the JTAG debug controller: op codes, STATUS bit positions
// and the access FSM state type.
package debug_control_pkg;

  localparam logic [7:0] OP_NOOP   = 8'h00;
  localparam logic [7:0] OP_HALT   = 8'h01;
  localparam logic [7:0] OP_RESUME = 8'h02;
  localparam logic [7:0] OP_RESET  = 8'h03;
  localparam logic [7:0] OP_READ   = 8'h04;
  localparam logic [7:0] OP_WRITE  = 8'h05;
  localparam logic [7:0] OP_STEP   = 8'h06;
  localparam logic [7:0] OP_STATUS = 8'h07;
  localparam logic [7:0] OP_ADDR   = 8'h80;
  localparam logic [7:0] OP_WDATA  = 8'h81;
  localparam logic [7:0] OP_CHSEL  = 8'h82;
  localparam logic [7:0] OP_FLAGS  = 8'h83;

  localparam int ST_BUSY  = 0;
  localparam int ST_TMO   = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_BADCH = 3;
  localparam int ST_HALT  = 4;
  localparam int ST_RST   = 5;
  localparam int ST_STEP  = 6;
  localparam int STATUS_W = 7;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/debug_reset_stretch.sv
// Holds resetn_out low for RST_STRETCH cycles after each req; a new req reloads the count.
module debug_reset_stretch #(
  parameter int RST_STRETCH = 1023
) (
  input  logic cpu_clk,
  input  logic sys_rstn,
  input  logic req,
  output logic resetn_out
);

  localparam int CW = (RST_STRETCH < 2) ? 1 : $clog2(RST_STRETCH + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt_q <= '0;
    end else if (req) begin
      cnt_q <= CW'(RST_STRETCH);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign resetn_out = (cnt_q == '0);

endmodule

// File: rtl/ff_sync.sv
// Two-flop level synchroniser for slow control signals crossing into cpu_clk.
module ff_sync #(
  parameter int W = 1
) (
  input  logic         cpu_clk,
  input  logic         sys_rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/debug_control_mc.sv
// JTAG user-op debug controller: memory channel accesses, status, CPU halt and reset.
// Define DEBUG_CONTROL_MC_STEP_EN to add the cpu_step output and the STEP op.
module debug_control_mc
  import debug_control_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int AW          = 64,
  parameter int DW          = 64,
  parameter int RST_STRETCH = 1023,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              cpu_clk,
  input  logic              sys_rstn,
  input  logic              jtag_op_ready,
  input  logic [7:0]        jtag_op,
  input  logic [DW-1:0]     jtag_data,
  output logic [DW-1:0]     user_data_out,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [NCH-1:0]    mem_ce,
  output logic [NCH-1:0]    mem_we,
  input  logic [NCH-1:0]    mem_ack,
  input  logic [NCH*DW-1:0] mem_rdata,
  output logic              cpu_halt,
  output logic              cpu_resetn_cpu
`ifdef DEBUG_CONTROL_MC_STEP_EN
  ,
  output logic              cpu_step
`endif
);

  // state | meaning
  // IDLE  | waiting for exec; register ops run and accesses launch here
  // REQ   | channel request held until ack or timeout; any exec is an overrun

  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC);
`ifdef DEBUG_CONTROL_MC_STEP_EN
  localparam logic STEP_PRESENT = 1'b1;
`else
  localparam logic STEP_PRESENT = 1'b0;
`endif

  acc_state_e state_q, state_d;

  logic                ready_sync, ready_d, exec;
  logic [2:0]          chsel_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q, udo_q, rdata_sel;
  logic                flag_inc_q, halt_q, wr_q;
  logic                tmo_err_q, ovr_q, badch_q;
  logic [TW-1:0]       tmo_cnt_q;
  logic [NCH-1:0]      ch_mask;
  logic                ch_bad, ack_sel, is_rw;
  logic                reg_exec, start, done, tmo_hit, ovr_set, bad_set, rst_req;
  logic [STATUS_W-1:0] status_vec;
`ifdef DEBUG_CONTROL_MC_STEP_EN
  logic                step_q;
`endif

  ff_sync #(.W(1)) u_ready_sync (
    .cpu_clk  (cpu_clk),
    .sys_rstn (sys_rstn),
    .d        (jtag_op_ready),
    .q        (ready_sync)
  );

  assign exec = ready_sync & ~ready_d;

  always_comb begin
    ch_mask   = '0;
    rdata_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chsel_q == 3'(c)) begin
        ch_mask[c] = 1'b1;
        rdata_sel  = mem_rdata[c*DW +: DW];
      end
    end
  end

  assign ch_bad  = ({1'b0, chsel_q} >= 4'(NCH));
  assign ack_sel = |(mem_ack & ch_mask);
  assign is_rw   = (jtag_op == OP_READ) || (jtag_op == OP_WRITE);

  always_comb begin
    status_vec           = '0;
    status_vec[ST_BUSY]  = (state_q == REQ);
    status_vec[ST_TMO]   = tmo_err_q;
    status_vec[ST_OVR]   = ovr_q;
    status_vec[ST_BADCH] = badch_q;
    status_vec[ST_HALT]  = halt_q;
    status_vec[ST_RST]   = ~cpu_resetn_cpu;
    status_vec[ST_STEP]  = STEP_PRESENT;
  end

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    reg_exec = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    tmo_hit  = 1'b0;
    ovr_set  = 1'b0;
    bad_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (exec) begin
          reg_exec = 1'b1;
          if (is_rw) begin
            if (ch_bad) begin
              bad_set = 1'b1;
            end else begin
              start   = 1'b1;
              state_d = REQ;
            end
          end
        end
      end
      REQ: begin
        ovr_set = exec;
        // ack wins over a timeout expiring in the same cycle
        if (ack_sel) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt_q == TW'(1)) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rst_req = reg_exec && (jtag_op == OP_RESET);

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      ready_d    <= 1'b0;
      chsel_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      flag_inc_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
      badch_q    <= 1'b0;
      halt_q     <= 1'b0;
      wr_q       <= 1'b0;
      tmo_cnt_q  <= '0;
      udo_q      <= '0;
`ifdef DEBUG_CONTROL_MC_STEP_EN
      step_q     <= 1'b0;
`endif
    end else begin
      ready_d <= ready_sync;
`ifdef DEBUG_CONTROL_MC_STEP_EN
      step_q  <= 1'b0;
`endif
      if (reg_exec) begin
        case (jtag_op)
          OP_HALT:             halt_q <= 1'b1;
          OP_RESUME, OP_RESET: halt_q <= 1'b0;
          OP_STATUS: begin
            udo_q     <= DW'(status_vec);
            tmo_err_q <= 1'b0;
            ovr_q     <= 1'b0;
            badch_q   <= 1'b0;
          end
          OP_ADDR:  addr_q     <= AW'(jtag_data);
          OP_WDATA: wdata_q    <= jtag_data;
          OP_CHSEL: chsel_q    <= jtag_data[2:0];
          OP_FLAGS: flag_inc_q <= jtag_data[0];
`ifdef DEBUG_CONTROL_MC_STEP_EN
          OP_STEP:  step_q     <= halt_q;
`endif
          default: ;
        endcase
      end
      if (bad_set) badch_q <= 1'b1;
      if (ovr_set) ovr_q <= 1'b1;
      if (start) begin
        wr_q      <= (jtag_op == OP_WRITE);
        tmo_cnt_q <= TO_LOAD;
      end else if ((state_q == REQ) && (tmo_cnt_q != '0)) begin
        tmo_cnt_q <= tmo_cnt_q - TW'(1);
      end
      if (tmo_hit) begin
        tmo_err_q <= 1'b1;
        wr_q      <= 1'b0;
      end
      if (done) begin
        wr_q <= 1'b0;
        if (!wr_q) udo_q <= rdata_sel;
        if (flag_inc_q) addr_q <= addr_q + AW'(DW / 8);
      end
    end
  end

  debug_reset_stretch #(.RST_STRETCH(RST_STRETCH)) u_rst_stretch (
    .cpu_clk    (cpu_clk),
    .sys_rstn   (sys_rstn),
    .req        (rst_req),
    .resetn_out (cpu_resetn_cpu)
  );

  assign mem_ce        = (state_q == REQ) ? ch_mask : '0;
  assign mem_we        = mem_ce & {NCH{wr_q}};
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign user_data_out = udo_q;
  assign cpu_halt      = halt_q;
`ifdef DEBUG_CONTROL_MC_STEP_EN
  assign cpu_step      = step_q;
`endif

endmodule

// File: tb/tb_debug_control_mc.sv
// Directed bench for debug_control_mc: a register/status vector table plus
// hand-written sequences for accesses, timeout, overrun, reset stretch and step.
module tb_debug_control_mc;
  import debug_control_pkg::*;

`ifdef DEBUG_CONTROL_MC_STEP_EN
  localparam logic [63:0] S6 = 64'h40;
`else
  localparam logic [63:0] S6 = 64'h0;
`endif

  logic         cpu_clk = 1'b0;
  logic         sys_rstn = 1'b0;
  logic         jtag_op_ready = 1'b0;
  logic [7:0]   jtag_op = 8'h00;
  logic [63:0]  jtag_data = '0;
  logic [63:0]  user_data_out, mem_addr, mem_wdata;
  logic [1:0]   mem_ce, mem_we;
  logic [1:0]   mem_ack = 2'b00;
  logic [127:0] mem_rdata;
  logic         cpu_halt, cpu_resetn_cpu;
`ifdef DEBUG_CONTROL_MC_STEP_EN
  logic         cpu_step;
`endif

  int           total = 0;
  int           bad = 0;
  logic [63:0]  rd_val = '0;
  int           ack_delay = -1;

  int           ce_cnt = 0, ce_len = 0, we_len = 0;
  int           ce0_total = 0, ce1_total = 0, step_cnt = 0;
  logic [63:0]  ce_addr = '0, ce_wdata = '0;

  assign mem_rdata = {rd_val ^ 64'hFFFF_0000_0000_0000, rd_val};

  always #5 cpu_clk = ~cpu_clk;

  debug_control_mc dut (
    .cpu_clk        (cpu_clk),
    .sys_rstn       (sys_rstn),
    .jtag_op_ready  (jtag_op_ready),
    .jtag_op        (jtag_op),
    .jtag_data      (jtag_data),
    .user_data_out  (user_data_out),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ce         (mem_ce),
    .mem_we         (mem_we),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .cpu_halt       (cpu_halt),
    .cpu_resetn_cpu (cpu_resetn_cpu)
`ifdef DEBUG_CONTROL_MC_STEP_EN
    ,
    .cpu_step       (cpu_step)
`endif
  );

  // memory responder: acks the active channel after ack_delay request cycles
  always @(negedge cpu_clk) begin
    if (mem_ce != 2'b00) begin
      ce_cnt = ce_cnt + 1;
      if (ce_cnt == 1) we_len = 0;
      ce_len = ce_cnt;
      if (mem_we == mem_ce) we_len = we_len + 1;
      if (mem_ce[0]) ce0_total = ce0_total + 1;
      if (mem_ce[1]) ce1_total = ce1_total + 1;
      ce_addr  = mem_addr;
      ce_wdata = mem_wdata;
      mem_ack  = (ack_delay >= 0 && ce_cnt == ack_delay + 1) ? mem_ce : 2'b00;
    end else begin
      ce_cnt  = 0;
      mem_ack = 2'b00;
    end
`ifdef DEBUG_CONTROL_MC_STEP_EN
    if (cpu_step) step_cnt = step_cnt + 1;
`endif
  end

  typedef struct {
    logic [7:0]  op;
    logic [63:0] data;
    logic        exp_halt;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [63:0] exp_udo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] op, input logic [63:0] d);
    @(negedge cpu_clk);
    jtag_op       = op;
    jtag_data     = d;
    jtag_op_ready = 1'b1;
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    jtag_op_ready = 1'b0;
    repeat (3) @(negedge cpu_clk);
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!ok) begin
        @(negedge cpu_clk);
        if (mem_ce == 2'b00) ok = 1'b1;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  // issues RESET and counts cpu_resetn_cpu low cycles; reissue > 0 sends
  // a second RESET whose load lands at the end of low cycle reissue+2
  task automatic rst_measure(input int reissue, output int low);
    low = 0;
    @(negedge cpu_clk);
    jtag_op       = OP_RESET;
    jtag_data     = '0;
    jtag_op_ready = 1'b1;
    repeat (3) @(posedge cpu_clk);
    for (int n = 1; n < 4000; n++) begin
      @(negedge cpu_clk);
      if (n == 1) jtag_op_ready = 1'b0;
      if (reissue > 0 && n == reissue) jtag_op_ready = 1'b1;
      if (reissue > 0 && n == reissue + 5) jtag_op_ready = 1'b0;
      if (cpu_resetn_cpu) break;
      low = low + 1;
    end
    jtag_op_ready = 1'b0;
    repeat (3) @(negedge cpu_clk);
  endtask

  initial begin
    int c0, c1, low;

    tbl[0] = '{OP_ADDR,   64'h100,                 1'b0, 64'h100, 64'h0, 64'h0};
    tbl[1] = '{OP_HALT,   64'h0,                   1'b1, 64'h100, 64'h0, 64'h0};
    tbl[2] = '{OP_STATUS, 64'h0,                   1'b1, 64'h100, 64'h0, 64'h10 | S6};
    tbl[3] = '{OP_RESUME, 64'h0,                   1'b0, 64'h100, 64'h0, 64'h10 | S6};
    tbl[4] = '{8'h55,     64'hFFFF,                1'b0, 64'h100, 64'h0, 64'h10 | S6};
    tbl[5] = '{OP_STEP,   64'h0,                   1'b0, 64'h100, 64'h0, 64'h10 | S6};
    tbl[6] = '{OP_STATUS, 64'h0,                   1'b0, 64'h100, 64'h0, S6};
    tbl[7] = '{OP_WDATA,  64'hDEAD_BEEF,           1'b0, 64'h100, 64'hDEAD_BEEF, S6};
    tbl[8] = '{OP_ADDR,   64'hFFFF_FFFF_FFFF_F123, 1'b0, 64'hFFFF_FFFF_FFFF_F123, 64'hDEAD_BEEF, S6};
    tbl[9] = '{OP_NOOP,   64'h0,                   1'b0, 64'hFFFF_FFFF_FFFF_F123, 64'hDEAD_BEEF, S6};

    #12;
    chk("rst_udo",    user_data_out, 64'h0);
    chk("rst_addr",   mem_addr, 64'h0);
    chk("rst_ce_we",  {60'h0, mem_ce, mem_we}, 64'h0);
    chk("rst_halt",   64'(cpu_halt), 64'h0);
    chk("rst_cpurst", 64'(cpu_resetn_cpu), 64'h1);
    @(negedge cpu_clk);
    sys_rstn = 1'b1;
    repeat (3) @(negedge cpu_clk);

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].op, tbl[i].data);
      chk($sformatf("tbl%0d_halt", i),  64'(cpu_halt), 64'(tbl[i].exp_halt));
      chk($sformatf("tbl%0d_addr", i),  mem_addr,      tbl[i].exp_addr);
      chk($sformatf("tbl%0d_wdata", i), mem_wdata,     tbl[i].exp_wdata);
      chk($sformatf("tbl%0d_udo", i),   user_data_out, tbl[i].exp_udo);
    end

    // write on channel 1, ack in the fourth request cycle
    do_op(OP_CHSEL, 64'd1);
    do_op(OP_ADDR, 64'h100);
    c0 = ce0_total;
    ack_delay = 3;
    do_op(OP_WRITE, 64'h0);
    wait_idle("wr_idle");
    chk("wr_ce_len",   64'(ce_len), 64'd4);
    chk("wr_we_len",   64'(we_len), 64'd4);
    chk("wr_addr",     ce_addr, 64'h100);
    chk("wr_wdata",    ce_wdata, 64'hDEAD_BEEF);
    chk("wr_ce0_idle", 64'(ce0_total - c0), 64'd0);
    chk("wr_addr_noinc", mem_addr, 64'h100);
    chk("wr_udo_keep", user_data_out, S6);

    // auto-increment reads on channel 0, then address wrap
    do_op(OP_FLAGS, 64'h1);
    do_op(OP_CHSEL, 64'd0);
    do_op(OP_ADDR, 64'h1000);
    ack_delay = 0;
    rd_val = 64'h11;
    do_op(OP_READ, 64'h0);
    wait_idle("rd1_idle");
    chk("rd1_addr", ce_addr, 64'h1000);
    chk("rd1_udo",  user_data_out, 64'h11);
    chk("rd1_len",  64'(ce_len), 64'd1);
    rd_val = 64'h22;
    do_op(OP_READ, 64'h0);
    wait_idle("rd2_idle");
    chk("rd2_addr", ce_addr, 64'h1008);
    chk("rd2_udo",  user_data_out, 64'h22);
    chk("rd2_next", mem_addr, 64'h1010);
    do_op(OP_ADDR, 64'hFFFF_FFFF_FFFF_FFF8);
    do_op(OP_READ, 64'h0);
    wait_idle("wrap_idle");
    chk("wrap_addr", ce_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("wrap_next", mem_addr, 64'h0);

    // timeout with an ADDR op dropped as overrun while the request is pending
    ack_delay = -1;
    do_op(OP_ADDR, 64'h200);
    do_op(OP_READ, 64'h0);
    do_op(OP_ADDR, 64'h300);
    chk("ovr_addr_hold", mem_addr, 64'h200);
    wait_idle("tmo_idle");
    chk("tmo_ce_len", 64'(ce_len), 64'd255);
    chk("tmo_addr",   mem_addr, 64'h200);
    do_op(OP_STATUS, 64'h0);
    chk("tmo_status1", user_data_out, 64'h6 | S6);
    do_op(OP_STATUS, 64'h0);
    chk("tmo_status2", user_data_out, S6);

    // channel 5 does not exist
    do_op(OP_CHSEL, 64'd5);
    c0 = ce0_total;
    c1 = ce1_total;
    do_op(OP_READ, 64'h0);
    repeat (4) @(negedge cpu_clk);
    chk("badch_no_ce", 64'((ce0_total - c0) + (ce1_total - c1)), 64'd0);
    do_op(OP_STATUS, 64'h0);
    chk("badch_status", user_data_out, 64'h8 | S6);
    do_op(OP_CHSEL, 64'd0);

`ifdef DEBUG_CONTROL_MC_STEP_EN
    do_op(OP_HALT, 64'h0);
    c0 = step_cnt;
    do_op(OP_STEP, 64'h0);
    chk("step_halted", 64'(step_cnt - c0), 64'd1);
    do_op(OP_RESUME, 64'h0);
    c0 = step_cnt;
    do_op(OP_STEP, 64'h0);
    chk("step_running", 64'(step_cnt - c0), 64'd0);
`endif

    // halt, then stretched CPU reset (plain and reloaded at low cycle 500)
    do_op(OP_HALT, 64'h0);
    chk("halt_set", 64'(cpu_halt), 64'd1);
    rst_measure(0, low);
    chk("rst_halt_clr", 64'(cpu_halt), 64'd0);
    chk("rst_len", 64'(low), 64'd1023);
    rst_measure(498, low);
    chk("rst_len_ext", 64'(low), 64'd1523);

    // sys_rstn in the middle of an access
    do_op(OP_HALT, 64'h0);
    do_op(OP_ADDR, 64'h400);
    do_op(OP_READ, 64'h0);
    chk("abort_ce_before", 64'(mem_ce), 64'd1);
    sys_rstn = 1'b0;
    #1;
    chk("abort_ce",   64'(mem_ce), 64'd0);
    chk("abort_addr", mem_addr, 64'h0);
    chk("abort_halt", 64'(cpu_halt), 64'd0);
    chk("abort_udo",  user_data_out, 64'h0);
    @(negedge cpu_clk);
    sys_rstn = 1'b1;
    repeat (3) @(negedge cpu_clk);
    chk("abort_idle", 64'(mem_ce), 64'd0);
    chk("abort_cpurst", 64'(cpu_resetn_cpu), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
